// File: rtl/spi_reg_controller.sv
// Register-access sequencer behind an SPI byte device: command decode, auto-increment writes, prefetched reads.
// Optional status preamble ({overrun, txn_count}) enabled by defining SPI_REG_CTRL_STATUS_EN.
module spi_reg_controller #(
    parameter int ADDR_BITS  = 7,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic [7:0]           tx_data,
    output logic                 tx_ready,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [7:0]           reg_wdata,
    output logic                 reg_wr,
    output logic                 reg_rd,
    input  logic [7:0]           reg_rdata,
    input  logic                 reg_rd_valid,
    output logic                 overrun
);
    localparam int TW = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, RD_REQ, RD_WAIT, RD_HOLD} state_t;

    state_t        state;
    logic [TW-1:0] rd_timer;
    logic [7:0]    preamble;
    logic          ovr_set;
    logic          ovr_clr;

    // A byte landing while a read is in flight cannot be answered in time.
    assign ovr_set = rx_valid && !spi_cs && (state == RD_REQ || state == RD_WAIT);

`ifdef SPI_REG_CTRL_STATUS_EN
    logic [6:0] txn_count;
    logic       cs_q;

    assign preamble = {overrun, txn_count};
    assign ovr_clr  = (state == IDLE) && !spi_cs;

    always_ff @(posedge clk) begin
        if (reset) begin
            txn_count <= 7'd0;
            cs_q      <= 1'b1;
        end else begin
            cs_q <= spi_cs;
            if (spi_cs && !cs_q)
                txn_count <= txn_count + 7'd1;
        end
    end
`else
    assign preamble = 8'h00;
    assign ovr_clr  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_timer  <= '0;
            tx_data   <= 8'h00;
            tx_ready  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            reg_wr  <= 1'b0;
            reg_rd  <= 1'b0;
            overrun <= ovr_set | (overrun & ~ovr_clr);
            if (spi_cs) begin
                // Deselect aborts everything, including a pending read.
                state    <= IDLE;
                tx_ready <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tx_data  <= preamble;
                        tx_ready <= 1'b1;
                        state    <= CMD;
                    end
                    CMD: begin
                        if (rx_valid) begin
                            reg_addr <= rx_data[ADDR_BITS-1:0];
                            if (rx_data[7]) begin
                                tx_ready <= 1'b0;
                                state    <= RD_REQ;
                            end else begin
                                tx_data <= 8'h00;
                                state   <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (reg_wr)
                            reg_addr <= reg_addr + ADDR_BITS'(1);
                        if (rx_valid) begin
                            reg_wdata <= rx_data;
                            reg_wr    <= 1'b1;
                        end
                    end
                    RD_REQ: begin
                        reg_rd   <= 1'b1;
                        rd_timer <= '0;
                        state    <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (reg_rd_valid) begin
                            tx_data  <= reg_rdata;
                            tx_ready <= 1'b1;
                            reg_addr <= reg_addr + ADDR_BITS'(1);
                            state    <= RD_HOLD;
                        end else if (rd_timer == TW'(RD_TIMEOUT)) begin
                            tx_data  <= 8'hFF;
                            tx_ready <= 1'b1;
                            reg_addr <= reg_addr + ADDR_BITS'(1);
                            state    <= RD_HOLD;
                        end else begin
                            rd_timer <= rd_timer + TW'(1);
                        end
                    end
                    RD_HOLD: begin
                        // The master consumed the prefetched byte; fetch the next register.
                        if (rx_valid) begin
                            tx_ready <= 1'b0;
                            state    <= RD_REQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
